// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: control-word field positions, default kill mask and stage indices shared by the control pipeline
package ctrl_pipe_pkg;
  localparam int CTRL_W = 16;
  localparam int REG_WE_BIT = 0;
  localparam int DMEM_WE_BIT = 1;
  localparam int PC_SEL_BIT = 2;
  localparam int BR_EN_BIT = 3;
  localparam int ALU_SEL_LSB = 4;
  localparam int ALU_SEL_W = 4;
  localparam int WB_SEL_LSB = 8;
  localparam int WB_SEL_W = 2;
  localparam int IMM_SEL_LSB = 10;
  localparam int IMM_SEL_W = 3;
  localparam logic [CTRL_W-1:0] KILL_MASK_DEF = CTRL_W'((1 << REG_WE_BIT) | (1 << DMEM_WE_BIT));
  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_WB = 2;
endpackage

// File: rtl/ctrl_stage.sv
// ctrl_stage: one control-word pipeline register with flush, stall hold and bubble insertion on upstream stall
module ctrl_stage #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] up_word,
  input  logic             up_valid,
  input  logic             up_stall,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] word,
  output logic             valid
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word  <= BUBBLE;
      valid <= 1'b0;
    end else if (flush) begin
      word  <= BUBBLE;
      valid <= 1'b0;
    end else if (!stall) begin
      word  <= up_stall ? BUBBLE : up_word;
      valid <= up_stall ? 1'b0 : up_valid;
    end
  end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: parametrised control-word pipeline with per-stage stall/flush, write-enable kill masking and retire counter
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter logic [WIDTH-1:0] KILL_MASK = WIDTH'(KILL_MASK_DEF),
  parameter int CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            ctrl_in,
  input  logic                        valid_in,
  input  logic [NUM_STAGES-1:0]       stall,
  input  logic [NUM_STAGES-1:0]       flush,
  input  logic                        cnt_clr,
  output logic [NUM_STAGES*WIDTH-1:0] ctrl_out,
  output logic [NUM_STAGES-1:0]       valid_out,
  output logic                        retire,
  output logic [CNT_W-1:0]            instret
);
  logic [WIDTH-1:0] words [NUM_STAGES];
  logic [NUM_STAGES-1:0] valids;
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] up_word;
    logic up_valid;
    logic up_stall;
    if (k == 0) begin : g_head
      assign up_word  = ctrl_in;
      assign up_valid = valid_in;
      assign up_stall = 1'b0;
    end else begin : g_body
      assign up_word  = words[k-1];
      assign up_valid = valids[k-1];
      assign up_stall = stall[k-1];
    end
    ctrl_stage #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .up_word  (up_word),
      .up_valid (up_valid),
      .up_stall (up_stall),
      .stall    (stall[k]),
      .flush    (flush[k]),
      .word     (words[k]),
      .valid    (valids[k])
    );
    assign ctrl_out[k*WIDTH +: WIDTH] = words[k] & ~(KILL_MASK & {WIDTH{~valids[k]}});
  end
  assign valid_out = valids;
  assign retire = valids[NUM_STAGES-1] & ~stall[NUM_STAGES-1];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) instret <= '0;
    else if (cnt_clr) instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed stimulus with a retire-word scoreboard and direct state checks for ctrl_pipe
module tb_ctrl_pipe;
  localparam int N = 3;
  localparam int W = 16;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] ctrl_in = '0;
  logic valid_in = 1'b0;
  logic [N-1:0] stall = '0;
  logic [N-1:0] flush = '0;
  logic cnt_clr = 1'b0;
  logic [N*W-1:0] ctrl_out;
  logic [N-1:0] valid_out;
  logic retire;
  logic [CW-1:0] instret;
  int passed = 0;
  int total = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] exp_w;
  ctrl_pipe #(.NUM_STAGES(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ctrl_in   (ctrl_in),
    .valid_in  (valid_in),
    .stall     (stall),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .ctrl_out  (ctrl_out),
    .valid_out (valid_out),
    .retire    (retire),
    .instret   (instret)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] stg(int k);
    return ctrl_out[k*W +: W];
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step(logic [W-1:0] ci, logic vi, logic [N-1:0] st, logic [N-1:0] fl, logic clr);
    ctrl_in = ci;
    valid_in = vi;
    stall = st;
    flush = fl;
    cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (retire) begin
      total++;
      if (sb.size() == 0) $display("FAIL retire_unexpected: got %h expected none", stg(N-1));
      else begin
        exp_w = sb.pop_front();
        if (stg(N-1) === exp_w) passed++;
        else $display("FAIL retire_word: got %h expected %h", stg(N-1), exp_w);
      end
    end
  end
  initial begin
    #1;
    chk("rst_valid", 64'(valid_out), 64'h0);
    chk("rst_ctrl", 64'(ctrl_out), 64'h0);
    chk("rst_instret", 64'(instret), 64'h0);
    chk("rst_retire", 64'(retire), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(16'h0101);
    sb.push_back(16'h0202);
    sb.push_back(16'h0303);
    step(16'h0101, 1'b1, 3'b000, 3'b000, 1'b0);
    chk("s0_first", 64'(stg(0)), 64'h0101);
    chk("valid_first", 64'(valid_out), 64'h1);
    step(16'h0202, 1'b1, 3'b000, 3'b000, 1'b0);
    step(16'h0303, 1'b1, 3'b000, 3'b000, 1'b0);
    chk("s2_lat3", 64'(stg(2)), 64'h0101);
    for (int i = 0; i < 3; i++) step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("stream_instret", 64'(instret), 64'h3);
    chk("stream_drained", 64'(valid_out), 64'h0);
    sb.push_back(16'h0013);
    step(16'h0013, 1'b1, 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(16'h0000, 1'b0, 3'b001, 3'b000, 1'b0);
      chk("s0_hold_word", 64'(stg(0)), 64'h0013);
      chk("s0_hold_valid", 64'(valid_out), 64'h1);
      chk("s1_bubble", 64'(stg(1)), 64'h0);
    end
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("s1_adv_word", 64'(stg(1)), 64'h0013);
    chk("s1_adv_valid", 64'(valid_out), 64'h2);
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("adv_once", 64'(valid_out), 64'h4);
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("hold_instret", 64'(instret), 64'h4);
    step(16'h00F3, 1'b1, 3'b000, 3'b000, 1'b0);
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("s1_f3", 64'(stg(1)), 64'h00F3);
    step(16'h0000, 1'b0, 3'b010, 3'b010, 1'b0);
    chk("flush_valid", 64'(valid_out), 64'h0);
    chk("flush_word", 64'(stg(1)), 64'h0);
    for (int i = 0; i < 3; i++) step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("flush_instret", 64'(instret), 64'h4);
    sb.push_back(16'h0003);
    step(16'h0003, 1'b1, 3'b000, 3'b000, 1'b0);
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("s2_loaded", 64'(valid_out), 64'h4);
    for (int i = 0; i < 3; i++) begin
      step(16'h0000, 1'b0, 3'b100, 3'b000, 1'b0);
      chk("s2_stall_retire", 64'(retire), 64'h0);
      chk("s2_stall_word", 64'(stg(2)), 64'h0003);
      chk("s2_stall_instret", 64'(instret), 64'h4);
    end
    stall = 3'b000;
    #1;
    chk("s2_release_retire", 64'(retire), 64'h1);
    @(posedge clk);
    #1;
    chk("s2_once_instret", 64'(instret), 64'h5);
    chk("s2_once_valid", 64'(valid_out), 64'h0);
    for (int i = 0; i < 10; i++) begin
      sb.push_back(16'h0100 + 16'(i));
      step(16'h0100 + 16'(i), 1'b1, 3'b000, 3'b000, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("cnt_max", 64'(instret), 64'hF);
    sb.push_back(16'h0A5A);
    step(16'h0A5A, 1'b1, 3'b000, 3'b000, 1'b0);
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("cnt_pre_wrap", 64'(instret), 64'hF);
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("cnt_wrap", 64'(instret), 64'h0);
    sb.push_back(16'h1111);
    sb.push_back(16'h2222);
    step(16'h1111, 1'b1, 3'b000, 3'b000, 1'b0);
    step(16'h2222, 1'b1, 3'b000, 3'b000, 1'b0);
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("cnt_one", 64'(instret), 64'h1);
    step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b1);
    chk("cnt_clr_wins", 64'(instret), 64'h0);
    sb.push_back(16'h3003);
    step(16'h3003, 1'b1, 3'b000, 3'b000, 1'b0);
    step(16'h4003, 1'b1, 3'b000, 3'b000, 1'b0);
    step(16'h5003, 1'b1, 3'b000, 3'b000, 1'b0);
    step(16'h6003, 1'b1, 3'b000, 3'b000, 1'b0);
    chk("inflight_valid", 64'(valid_out), 64'h7);
    chk("inflight_instret", 64'(instret), 64'h1);
    ctrl_in = '0;
    valid_in = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("async_valid", 64'(valid_out), 64'h0);
    chk("async_ctrl", 64'(ctrl_out), 64'h0);
    chk("async_instret", 64'(instret), 64'h0);
    chk("async_no_edge", 64'(clk), 64'h1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(16'h0000, 1'b0, 3'b000, 3'b000, 1'b0);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
